// File: rtl/sc_io_pkg.sv
// sc_io_pkg: shared constants for the sc_io_ctrl I/O block.
// Holds the register map, data width and debounce state encoding.
package sc_io_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] ADDR_ONE = 8'hC0;
  localparam logic [7:0] ADDR_TWO = 8'hC4;
  localparam logic [7:0] ADDR_LED = 8'hC8;
  localparam logic [7:0] ADDR_SW  = 8'hD0;
  localparam logic [7:0] ADDR_KEY = 8'hD4;
  localparam logic [7:0] ADDR_EVT = 8'hD8;

  localparam logic [1:0] ST_REL     = 2'd0;
  localparam logic [1:0] ST_REL_CHK = 2'd1;
  localparam logic [1:0] ST_PRS     = 2'd2;
  localparam logic [1:0] ST_PRS_CHK = 2'd3;

endpackage

// File: rtl/sc_key_debounce.sv
// sc_key_debounce: 2-flop key synchronizer plus optional debounce FSM.
// SC_IO_DEBOUNCE_EN selects the FSM; otherwise the synced edge is used.
module sc_key_debounce
  import sc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
    end
  end

`ifdef SC_IO_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       st_q;
  logic [1:0]       st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Entering a CHK state already counts the first stable cycle.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    press = 1'b0;
    unique case (st_q)
      ST_REL: begin
        if (!s2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            st_d  = ST_PRS;
            press = 1'b1;
          end else begin
            st_d  = ST_REL_CHK;
            cnt_d = CNT_W'(1);
          end
        end
      end
      ST_REL_CHK: begin
        if (s2_q) begin
          st_d  = ST_REL;
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          st_d  = ST_PRS;
          cnt_d = '0;
          press = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRS: begin
        if (s2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            st_d = ST_REL;
          end else begin
            st_d  = ST_PRS_CHK;
            cnt_d = CNT_W'(1);
          end
        end
      end
      ST_PRS_CHK: begin
        if (!s2_q) begin
          st_d  = ST_PRS;
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          st_d  = ST_REL;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        st_d  = ST_REL;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q  <= ST_REL;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign pressed = (st_q == ST_PRS) || (st_q == ST_PRS_CHK);
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(DEBOUNCE_CYCLES);

  // s1 low while s2 still high: s2 falls on this edge.
  assign pressed = ~s2_q;
  assign press   = s2_q & ~s1_q;
`endif

endmodule

// File: rtl/sc_io_ctrl.sv
// sc_io_ctrl: memory-mapped display operands, LEDs, switches and keys.
// Optional key debounce FSMs enabled by defining SC_IO_DEBOUNCE_EN.
module sc_io_ctrl
  import sc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  input  logic              we,
  output logic [DATA_W-1:0] dataout,
  input  logic [9:0]        sw,
  input  logic [3:0]        key,
  output logic [3:0]        one,
  output logic [3:0]        two,
  output logic [9:0]        led
);

  logic [3:0] one_q, one_d;
  logic [3:0] two_q, two_d;
  logic [9:0] led_q, led_d;
  logic [3:0] evt_q, evt_d;
  logic [9:0] sw_s1_q, sw_s2_q;
  logic [3:0] key_prs;
  logic [3:0] key_evt;
  logic [3:0] w1c;

  logic [5:0] word;
  logic       sel_one, sel_two, sel_led;
  logic       sel_sw, sel_key, sel_evt;

  logic       unused_bits;
  assign unused_bits = ^{addr[31:8], addr[1:0], datain[31:10]};

  assign word    = addr[7:2];
  assign sel_one = (word == ADDR_ONE[7:2]);
  assign sel_two = (word == ADDR_TWO[7:2]);
  assign sel_led = (word == ADDR_LED[7:2]);
  assign sel_sw  = (word == ADDR_SW[7:2]);
  assign sel_key = (word == ADDR_KEY[7:2]);
  assign sel_evt = (word == ADDR_EVT[7:2]);

  for (genvar i = 0; i < 4; i++) begin : g_key
    sc_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock  (clock),
      .reset  (reset),
      .key_n  (key[i]),
      .pressed(key_prs[i]),
      .press  (key_evt[i])
    );
  end

  // A press in the same cycle as its W1C wins.
  always_comb begin
    one_d = one_q;
    two_d = two_q;
    led_d = led_q;
    w1c   = 4'h0;
    if (we && sel_one) one_d = datain[3:0];
    if (we && sel_two) two_d = datain[3:0];
    if (we && sel_led) led_d = datain[9:0];
    if (we && sel_evt) w1c = datain[3:0];
    evt_d = (evt_q & ~w1c) | key_evt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      one_q   <= '0;
      two_q   <= '0;
      led_q   <= '0;
      evt_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      one_q   <= one_d;
      two_q   <= two_d;
      led_q   <= led_d;
      evt_q   <= evt_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_comb begin
    dataout = '0;
    unique case (1'b1)
      sel_one: dataout[3:0] = one_q;
      sel_two: dataout[3:0] = two_q;
      sel_led: dataout[9:0] = led_q;
      sel_sw:  dataout[9:0] = sw_s2_q;
      sel_key: dataout[3:0] = key_prs;
      sel_evt: dataout[3:0] = evt_q;
      default: dataout = '0;
    endcase
  end

  assign one = one_q;
  assign two = two_q;
  assign led = led_q;

endmodule

// File: tb/tb_sc_io_ctrl.sv
// tb_sc_io_ctrl: bus vector table plus key/switch timing sequences.
// Key latencies follow SC_IO_DEBOUNCE_EN.
module tb_sc_io_ctrl;

  localparam int DB = 16;
`ifdef SC_IO_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
  localparam bit DBE = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit DBE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] datain = '0;
  logic        we = 1'b0;
  logic [31:0] dataout;
  logic [9:0]  sw = '0;
  logic [3:0]  key = 4'hF;
  logic [3:0]  one;
  logic [3:0]  two;
  logic [9:0]  led;

  int total = 0;
  int bad = 0;

  sc_io_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .datain (datain),
    .we     (we),
    .dataout(dataout),
    .sw     (sw),
    .key    (key),
    .one    (one),
    .two    (two),
    .led    (led)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] sb_q[$];
  logic [31:0] rd_v;
  logic [31:0] exp_v;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dataout;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    datain = d;
    we = 1'b1;
    tick(1);
    we = 1'b0;
    datain = '0;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  initial begin
    logic [31:0] ra[6];
    ra[0] = 32'hC0; ra[1] = 32'hC4; ra[2] = 32'hC8;
    ra[3] = 32'hD0; ra[4] = 32'hD4; ra[5] = 32'hD8;

    vecs[0]  = '{1'b1, 32'hC0,  32'h0000_0007, 32'hC0, 32'h7};
    vecs[1]  = '{1'b1, 32'hC4,  32'hFFFF_FFFC, 32'hC4, 32'hC};
    vecs[2]  = '{1'b1, 32'hE0,  32'hFFFF_FFFF, 32'hE0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,   32'h0,         32'hC0, 32'h7};
    vecs[4]  = '{1'b1, 32'hC8,  32'hFFFF_F155, 32'hC8, 32'h155};
    vecs[5]  = '{1'b1, 32'hD0,  32'h0000_03FF, 32'hD0, 32'h0};
    vecs[6]  = '{1'b1, 32'hD4,  32'h0000_000F, 32'hD4, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,   32'h0,         32'hC3, 32'h7};
    vecs[8]  = '{1'b1, 32'h1C0, 32'h0000_0003, 32'hC0, 32'h3};
    vecs[9]  = '{1'b1, 32'hC0,  32'h0000_0010, 32'hC0, 32'h0};
    vecs[10] = '{1'b0, 32'h0,   32'h0,         32'hCC, 32'h0};

    tick(3);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rd(ra[i], rd_v);
      chk($sformatf("reset_rd_%0h", ra[i]), rd_v, 32'h0);
    end
    chk("reset_ports", {18'h0, one, two, led}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      else tick(1);
      sb_q.push_back(vecs[i].exp);
      rd(vecs[i].raddr, rd_v);
      exp_v = sb_q.pop_front();
      chk($sformatf("vec%0d", i), rd_v, exp_v);
      if (i == 1) chk("one_two_ports", {24'h0, one, two}, 32'h7C);
      if (i == 4) chk("led_port", {22'h0, led}, 32'h155);
    end

    sw = 10'h2A5;
    tick(1);
    chk_rd("sw_lat1", 32'hD0, 32'h0);
    tick(1);
    chk_rd("sw_lat2", 32'hD0, 32'h2A5);

    key[2] = 1'b0;
    tick(LAT - 1);
    chk_rd("k2_early_key", 32'hD4, 32'h0);
    chk_rd("k2_early_evt", 32'hD8, 32'h0);
    tick(1);
    chk_rd("k2_key", 32'hD4, 32'h4);
    chk_rd("k2_evt", 32'hD8, 32'h4);
    tick(20 - LAT);
    key[2] = 1'b1;
    tick(5);
    chk_rd("k2_glitch_key", 32'hD4, DBE ? 32'h4 : 32'h0);
    key[2] = 1'b0;
    tick(LAT + 1);
    chk_rd("k2_hold_key", 32'hD4, 32'h4);
    chk_rd("k2_hold_evt", 32'hD8, 32'h4);
    wr(32'hD8, 32'h4);
    chk_rd("k2_w1c", 32'hD8, 32'h0);
    key[2] = 1'b1;
    tick(LAT + 2);
    chk_rd("k2_rel_key", 32'hD4, 32'h0);
    chk_rd("k2_rel_evt", 32'hD8, 32'h0);

    for (int r = 0; r < 5; r++) begin
      key[0] = 1'b0;
      tick(10);
      key[0] = 1'b1;
      tick(1);
    end
    tick(2);
    chk_rd("k0_bounce_evt", 32'hD8, DBE ? 32'h0 : 32'h1);
    chk_rd("k0_bounce_key", 32'hD4, 32'h0);
    wr(32'hD8, 32'hF);

    key[1] = 1'b0;
    tick(LAT - 1);
    chk_rd("k1_pre_evt", 32'hD8, 32'h0);
    wr(32'hD8, 32'h2);
    chk_rd("k1_set_wins", 32'hD8, 32'h2);
    chk_rd("k1_key", 32'hD4, 32'h2);
    wr(32'hD8, 32'h2);
    chk_rd("k1_clear", 32'hD8, 32'h0);
    key[1] = 1'b1;
    tick(LAT + 2);
    chk_rd("k1_rel", 32'hD4, 32'h0);

    wr(32'hC0, 32'h9);
    key[3] = 1'b0;
    tick(2 + 10);
    reset = 1'b1;
    addr = 32'hC0;
    datain = 32'h5;
    we = 1'b1;
    tick(1);
    reset = 1'b0;
    we = 1'b0;
    datain = '0;
    chk("rst_over_we", {28'h0, one}, 32'h0);
    chk_rd("k3_rst_evt", 32'hD8, 32'h0);
    chk_rd("k3_rst_key", 32'hD4, 32'h0);
    tick(LAT - 1);
    chk_rd("k3_fresh_early", 32'hD8, 32'h0);
    tick(1);
    chk_rd("k3_fresh_evt", 32'hD8, 32'h8);
    chk_rd("k3_fresh_key", 32'hD4, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
